// File: rtl/gauss_pkg.sv
// Shared types and constants for the 3x3 Gaussian smoothing pipeline.
// Border loss and fill depth derive from the kernel span.
package gauss_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun,
    StDone
  } gauss_state_e;

  localparam int unsigned DefImgW    = 640;
  localparam int unsigned DefImgH    = 480;
  localparam int unsigned KernelSpan = 3;
  localparam int unsigned KernelHalf = KernelSpan / 2;
  // First row/column index at which a full window is available.
  localparam int unsigned FirstFull  = KernelSpan - 1;

endpackage

// File: rtl/raster_counter.sv
// Raster column/row position counter with wrap and last-pixel flags.
// start_i takes the current pixel as (0,0) and advances past it in one step.
module raster_counter #(
  parameter int unsigned Width  = 640,
  parameter int unsigned Height = 480,
  parameter int unsigned CW     = 10,
  parameter int unsigned RW     = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          step_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          last_col_o,
  output logic          last_pix_o
);

  localparam logic [CW-1:0] ColLast = CW'(Width - 1);
  localparam logic [RW-1:0] RowLast = RW'(Height - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  assign col_o      = col_q;
  assign row_o      = row_q;
  assign last_col_o = (col_q == ColLast);
  assign last_pix_o = last_col_o && (row_q == RowLast);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (start_i) begin
      col_d = CW'(1);
      row_d = '0;
    end else if (step_i) begin
      if (last_col_o) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/gaussian_window_ctrl.sv
// Frame sequencer for the 3x3 Gaussian datapath: gates line-buffer shifts and
// flags interior windows with frame markers aligned to the filter output.
module gaussian_window_ctrl
  import gauss_pkg::*;
#(
  parameter int unsigned IMG_W = DefImgW,
  parameter int unsigned IMG_H = DefImgH,
  parameter int unsigned CW    = 10,
  parameter int unsigned RW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic          in_ready,
  output logic          shift_en,
  output logic          out_valid,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_eof,
  output logic [CW-1:0] out_col,
  output logic [RW-1:0] out_row,
  output logic          sof_err
);

  gauss_state_e state_q, state_d;

  logic [CW-1:0] pos_col;
  logic [RW-1:0] pos_row;
  logic          last_col, last_pix;
  logic          cnt_start, cnt_step;
  logic          accept, at_origin;

  logic          valid_q, valid_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;
  logic          err_q, err_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  raster_counter #(
    .Width  (IMG_W),
    .Height (IMG_H),
    .CW     (CW),
    .RW     (RW)
  ) u_raster_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (cnt_start),
    .step_i     (cnt_step),
    .col_o      (pos_col),
    .row_o      (pos_row),
    .last_col_o (last_col),
    .last_pix_o (last_pix)
  );

  assign in_ready  = (state_q != StDone);
  assign accept    = in_valid & in_ready;
  assign shift_en  = accept;
  assign at_origin = (pos_col == '0) && (pos_row == '0);

  always_comb begin
    state_d   = state_q;
    cnt_start = 1'b0;
    cnt_step  = 1'b0;
    valid_d   = 1'b0;
    sof_d     = 1'b0;
    eol_d     = 1'b0;
    eof_d     = 1'b0;
    err_d     = 1'b0;
    col_d     = col_q;
    row_d     = row_q;
    unique case (state_q)
      StIdle: begin
        // Unmarked pixels are shifted in but leave the position at (0,0).
        if (accept && in_sof) begin
          cnt_start = 1'b1;
          state_d   = StFill;
        end
      end
      StFill, StRun: begin
        if (accept) begin
          if (in_sof && !at_origin) begin
            cnt_start = 1'b1;
            err_d     = 1'b1;
            state_d   = StFill;
          end else begin
            cnt_step = 1'b1;
            if (state_q == StFill && pos_row == RW'(FirstFull) && pos_col == '0) begin
              state_d = StRun;
            end
            if (state_q == StRun && pos_col >= CW'(FirstFull)) begin
              valid_d = 1'b1;
              col_d   = pos_col - CW'(KernelHalf);
              row_d   = pos_row - RW'(KernelHalf);
              sof_d   = (pos_row == RW'(FirstFull)) && (pos_col == CW'(FirstFull));
              eol_d   = last_col;
              eof_d   = last_pix;
            end
            if (state_q == StRun && last_pix) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      err_q   <= err_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sof   = sof_q;
  assign out_eol   = eol_q;
  assign out_eof   = eof_q;
  assign out_col   = col_q;
  assign out_row   = row_q;
  assign sof_err   = err_q;

endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Bench for gaussian_window_ctrl on a 5x4 frame: table of per-pixel vectors,
// scoreboard of expected windows tagged with their output cycle.
module tb_gaussian_window_ctrl;

  localparam int unsigned W  = 5;
  localparam int unsigned H  = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned RW = 3;
  localparam int NPix = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_sof;
  logic          in_ready, shift_en;
  logic          out_valid, out_sof, out_eol, out_eof, sof_err;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;

  gaussian_window_ctrl #(
    .IMG_W (W),
    .IMG_H (H),
    .CW    (CW),
    .RW    (RW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .shift_en  (shift_en),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .out_col   (out_col),
    .out_row   (out_row),
    .sof_err   (sof_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int col;
    int row;
    bit sof;
    bit eol;
    bit eof;
    int cyc;
  } exp_t;

  typedef struct {
    bit   in_sof;
    bit   has_out;
    exp_t exp;
  } vec_t;

  vec_t fv[NPix];
  exp_t sbq[$];
  exp_t mon_e;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit mon_en = 0;
  int n_valid = 0, n_eof = 0, n_err = 0, n_shift = 0, n_rdy_low = 0, n_consec = 0;
  int err_cyc = -1;
  int hold_col = 0, hold_row = 0;
  bit prev_valid = 0;
  int first_tag, last_tag;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
  endtask

  task automatic set_out(input int k, input int c, input int r, input bit s, input bit l,
                         input bit f);
    fv[k].has_out = 1'b1;
    fv[k].exp.col = c;
    fv[k].exp.row = r;
    fv[k].exp.sof = s;
    fv[k].exp.eol = l;
    fv[k].exp.eof = f;
  endtask

  // Monitor: sampled on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("shift_en_eq", int'(shift_en), int'(in_valid & in_ready));
      if (shift_en) n_shift++;
      if (!in_ready) n_rdy_low++;
      if (sof_err) begin
        n_err++;
        err_cyc = cyc;
      end
      if (out_valid) begin
        n_valid++;
        if (out_eof) n_eof++;
        if (prev_valid) n_consec++;
        if (sbq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("out_cycle", cyc, mon_e.cyc);
          chk("out_col", int'(out_col), mon_e.col);
          chk("out_row", int'(out_row), mon_e.row);
          chk("out_sof", int'(out_sof), int'(mon_e.sof));
          chk("out_eol", int'(out_eol), int'(mon_e.eol));
          chk("out_eof", int'(out_eof), int'(mon_e.eof));
        end
        hold_col = int'(out_col);
        hold_row = int'(out_row);
      end else begin
        chk("markers_idle", int'({out_sof, out_eol, out_eof}), 0);
        chk("col_hold", int'(out_col), hold_col);
        chk("row_hold", int'(out_row), hold_row);
      end
      prev_valid = out_valid;
    end
  end

  task automatic drive_pix(input bit sof, input bit has_out, input exp_t ex, output int tag);
    int w;
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    in_sof   = sof;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 8) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      tag = -1;
    end else begin
      tag = cyc + 1;
      if (has_out) begin
        ex.cyc = tag;
        sbq.push_back(ex);
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic run_frame(input bit gaps, input int first);
    int tag;
    for (int k = first; k < NPix; k++) begin
      if (gaps && k > first) idle_cycle();
      drive_pix(fv[k].in_sof, fv[k].has_out, fv[k].exp, tag);
      if (k == first) first_tag = tag;
      last_tag = tag;
    end
  endtask

  task automatic finish_frame();
    idle_cycle();
    @(negedge clk);
    chk("done_ready_low", int'(in_ready), 0);
    @(negedge clk);
    chk("idle_ready_high", int'(in_ready), 1);
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk("scoreboard_drain", sbq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int v0, e0, r0, s0, c0, er0, tag, rtag, last1;
    exp_t none;
    none = '{0, 0, 1'b0, 1'b0, 1'b0, 0};
    for (int k = 0; k < NPix; k++) begin
      fv[k].in_sof  = (k == 0);
      fv[k].has_out = 1'b0;
      fv[k].exp     = none;
    end
    set_out(12, 1, 1, 1'b1, 1'b0, 1'b0);
    set_out(13, 2, 1, 1'b0, 1'b0, 1'b0);
    set_out(14, 3, 1, 1'b0, 1'b1, 1'b0);
    set_out(17, 1, 2, 1'b0, 1'b0, 1'b0);
    set_out(18, 2, 2, 1'b0, 1'b0, 1'b0);
    set_out(19, 3, 2, 1'b0, 1'b1, 1'b1);

    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    #3;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_markers", int'({out_sof, out_eol, out_eof}), 0);
    chk("rst_sof_err", int'(sof_err), 0);
    chk("rst_out_col", int'(out_col), 0);
    chk("rst_out_row", int'(out_row), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Continuous frame.
    v0 = n_valid; e0 = n_eof; r0 = n_rdy_low; s0 = n_shift; er0 = n_err;
    run_frame(1'b0, 0);
    finish_frame();
    drain();
    chk("cont_valid_count", n_valid - v0, 6);
    chk("cont_eof_count", n_eof - e0, 1);
    chk("cont_ready_low", n_rdy_low - r0, 1);
    chk("cont_shift_count", n_shift - s0, NPix);
    chk("cont_err_count", n_err - er0, 0);

    // Same frame with a bubble between every pixel.
    v0 = n_valid; s0 = n_shift; c0 = n_consec;
    run_frame(1'b1, 0);
    finish_frame();
    drain();
    chk("gap_valid_count", n_valid - v0, 6);
    chk("gap_shift_count", n_shift - s0, NPix);
    chk("gap_no_consec_valid", n_consec - c0, 0);

    // Forced restart at pixel (2,1).
    v0 = n_valid; e0 = n_eof; er0 = n_err;
    for (int k = 0; k <= 10; k++) drive_pix(fv[k].in_sof, 1'b0, none, tag);
    drive_pix(1'b1, 1'b0, none, rtag);
    run_frame(1'b0, 1);
    finish_frame();
    drain();
    chk("restart_err_count", n_err - er0, 1);
    chk("restart_err_cycle", err_cyc, rtag);
    chk("restart_valid_count", n_valid - v0, 6);
    chk("restart_eof_count", n_eof - e0, 1);

    // Unmarked pixels in IDLE are discarded, then a normal frame.
    v0 = n_valid; s0 = n_shift; er0 = n_err;
    for (int k = 0; k < 7; k++) drive_pix(1'b0, 1'b0, none, tag);
    idle_cycle();
    drain();
    chk("discard_valid_count", n_valid - v0, 0);
    chk("discard_shift_count", n_shift - s0, 7);
    chk("discard_err_count", n_err - er0, 0);
    v0 = n_valid; e0 = n_eof;
    run_frame(1'b0, 0);
    finish_frame();
    drain();
    chk("post_discard_valid", n_valid - v0, 6);
    chk("post_discard_eof", n_eof - e0, 1);

    // Asynchronous reset just after the first interior window is accepted.
    for (int k = 0; k <= 12; k++) drive_pix(fv[k].in_sof, 1'b0, none, tag);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_sof", int'(out_sof), 0);
    chk("arst_out_col", int'(out_col), 0);
    chk("arst_out_row", int'(out_row), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    sbq.delete();
    hold_col = 0;
    hold_row = 0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_release_ready", int'(in_ready), 1);
    v0 = n_valid; e0 = n_eof;
    for (int k = 0; k < 3; k++) drive_pix(1'b0, 1'b0, none, tag);
    run_frame(1'b0, 0);
    finish_frame();
    drain();
    chk("arst_frame_valid", n_valid - v0, 6);
    chk("arst_frame_eof", n_eof - e0, 1);

    // Back-to-back frames separated only by the DONE cycle.
    v0 = n_valid; e0 = n_eof; r0 = n_rdy_low;
    run_frame(1'b0, 0);
    last1 = last_tag;
    run_frame(1'b0, 0);
    chk("b2b_gap_cycles", first_tag - last1, 2);
    finish_frame();
    drain();
    chk("b2b_valid_count", n_valid - v0, 12);
    chk("b2b_eof_count", n_eof - e0, 2);
    chk("b2b_ready_low", n_rdy_low - r0, 2);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
